pong_rally_ctrl: RTL and testbench
==================================

// Module: pong_rally_ctrl
// PURPOSE
//   Game-level rally/scoring controller for the Pong core, clocked by the frame-rate tick clk_div.
//   Consumes the ball x-position from the ball-physics stage and detects goals.
//   Owns the packed 8-bit score and sequences idle/serve/rally/point/game-over.
//   Drives the physics stage's ball_reset / ball_run / serve direction controls.
// PARAMETERS
//   LEFT_GOAL    10   ball_x <= this during rally = player point (ball passed opponent)
//   RIGHT_GOAL   630  ball_x >= this during rally = opponent point
//   WIN_SCORE    11   points to win; legal range 1..15
//   SERVE_DELAY  30   frames between ball_reset pulse and ball_run rising
//   POINT_HOLD   60   frames the ball stays frozen after a goal
//   CNT_W        6    frame-counter width; must hold max(SERVE_DELAY, POINT_HOLD)
// PORTS
//   clk_div      in   1   frame tick clock (one rising edge per video frame)
//   rst_n        in   1   reset, synchronous, active-low
//   ball_x       in   10  current ball x position from physics stage
//   serve_btn    in   1   serve request, level; internally rising-edge detected
//   score        out  8   [7:4] opponent score, [3:0] player score
//   ball_reset   out  1   1-frame pulse: physics recentres ball (320,240)
//   ball_run     out  1   1 = physics may advance ball; 0 = ball frozen
//   serve_dir_x  out  1   ball x direction to load on ball_reset; 1 = right
//   game_over    out  1   high while in GAME_OVER
//   winner       out  1   valid when game_over: 1 = player, 0 = opponent
//   state        out  3   current FSM state encoding (debug)
// BEHAVIOUR
//   Reset (rst_n low at clk_div edge, any state): state=IDLE, score=0, ball_reset=0, ball_run=0,
//     serve_dir_x=1, game_over=0, winner=0, counter=0, serve-edge register=0.
//   serve_edge = serve_btn & ~serve_btn_q; serve_btn_q is registered every edge.
//   States: IDLE=0, SERVE=1, RALLY=2, POINT=3, GAME_OVER=4; 5..7 unreachable -> IDLE next edge.
//   IDLE: ball_run=0. On serve_edge -> SERVE; ball_reset=1 for that first SERVE frame; counter=0.
//   SERVE: counter increments each frame; ball_reset only in the first frame.
//     When counter == SERVE_DELAY-1 -> RALLY next edge; ball_run=1 from RALLY entry.
//   RALLY: ball_run=1. Goal checks use the registered ball_x sampled at this edge.
//     ball_x <= LEFT_GOAL: player nibble +1, serve_dir_x<=0, -> POINT.
//     ball_x >= RIGHT_GOAL: opponent nibble +1, serve_dir_x<=1, -> POINT.
//     Both true (misconfig): left check wins. Score update and POINT entry happen at the same edge.
//   POINT: ball_run=0, counter counts POINT_HOLD frames.
//     At end, if either nibble == WIN_SCORE -> GAME_OVER: winner=(player nibble==WIN_SCORE), game_over=1.
//     Otherwise -> SERVE with ball_reset pulse, counter=0.
//   GAME_OVER: score held, ball_run=0. serve_edge -> score=0, game_over=0, serve_dir_x=1,
//     -> SERVE with ball_reset pulse.
//   Score nibbles saturate at 15 and never wrap; they increment only in RALLY, by exactly 1 per goal.
//   serve_btn held high produces one serve only; it needs a 0 then 1 to serve again.
//   serve_edge in SERVE/RALLY/POINT: ignored.
//   All outputs are registered: no combinational path from ball_x or serve_btn to any output.
// CONFIGURATION
//   PONG_AUTO_SERVE_EN defined: IDLE and GAME_OVER auto-advance to SERVE after SERVE_DELAY frames,
//     with no button needed. GAME_OVER clears the score on that transition. serve_edge still works
//     and serves early.
//   PONG_AUTO_SERVE_EN undefined: IDLE and GAME_OVER wait indefinitely for serve_edge.
// TESTING
//   Reset then serve_btn 0->1: ball_reset high exactly 1 frame; ball_run rises 30 frames later; state=2.
//   RALLY, ball_x=8: next edge score=8'h01, ball_run=0, serve_dir_x=0.
//     60 frames later ball_reset pulses, then ball_run again after 30 frames.
//   RALLY, ball_x=632: score=8'h10, serve_dir_x=1.
//   Opponent at 10, ball_x=632: score=8'hB0; after hold, game_over=1, winner=0.
//     ball_run stays 0 until serve_edge, then score=8'h00.
//   serve_btn held high 200 frames from IDLE: exactly one SERVE entry and one ball_reset pulse.
//   rst_n low for 1 edge mid-RALLY with score=8'h35: next edge score=0, state=IDLE, ball_run=0.
//   PONG_AUTO_SERVE_EN build, serve_btn=0 after reset: ball_reset pulses after 30 frames,
//     ball_run rises 30 frames after that.

Source files
------------

// File: rtl/pong_rally_ctrl.sv
// Rally/scoring controller for the Pong core: serve sequencing, goal detection, packed score.
// Optional build macro PONG_AUTO_SERVE_EN makes IDLE/GAME_OVER serve on their own after SERVE_DELAY frames.
module pong_rally_ctrl #(
    parameter int LEFT_GOAL   = 10,
    parameter int RIGHT_GOAL  = 630,
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_DELAY = 30,
    parameter int POINT_HOLD  = 60,
    parameter int CNT_W       = 6
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic [9:0] ball_x_i,
    input  logic       serve_btn_i,
    output logic [7:0] score_o,
    output logic       ball_reset_o,
    output logic       ball_run_o,
    output logic       serve_dir_x_o,
    output logic       game_over_o,
    output logic       winner_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_RALLY     = 3'd2,
        S_POINT     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

`ifdef PONG_AUTO_SERVE_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_HOLD - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       score_q, score_d;
    logic             reset_q, reset_d;
    logic             run_q, run_d;
    logic             dir_q, dir_d;
    logic             go_q, go_d;
    logic             win_q, win_d;
    logic             btn_q;
    logic             serve_edge, auto_due;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign serve_edge = serve_btn_i & ~btn_q;
    assign auto_due   = AUTO & (cnt_q == SERVE_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        reset_d = 1'b0;
        run_d   = 1'b0;
        dir_d   = dir_q;
        go_d    = go_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = AUTO ? cnt_q + CNT_W'(1) : cnt_q;
                if (serve_edge || auto_due) begin
                    state_d = S_SERVE;
                    reset_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_SERVE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SERVE_LAST) begin
                    state_d = S_RALLY;
                    run_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_RALLY: begin
                run_d = 1'b1;
                // Left check first so a misconfigured overlap still scores one goal
                if (ball_x_i <= 10'(LEFT_GOAL)) begin
                    score_d[3:0] = sat_inc(score_q[3:0]);
                    dir_d        = 1'b0;
                    state_d      = S_POINT;
                    run_d        = 1'b0;
                    cnt_d        = '0;
                end else if (ball_x_i >= 10'(RIGHT_GOAL)) begin
                    score_d[7:4] = sat_inc(score_q[7:4]);
                    dir_d        = 1'b1;
                    state_d      = S_POINT;
                    run_d        = 1'b0;
                    cnt_d        = '0;
                end
            end
            S_POINT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == POINT_LAST) begin
                    cnt_d = '0;
                    if (score_q[3:0] == WIN || score_q[7:4] == WIN) begin
                        state_d = S_GAME_OVER;
                        go_d    = 1'b1;
                        win_d   = (score_q[3:0] == WIN);
                    end else begin
                        state_d = S_SERVE;
                        reset_d = 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                cnt_d = AUTO ? cnt_q + CNT_W'(1) : cnt_q;
                if (serve_edge || auto_due) begin
                    score_d = '0;
                    go_d    = 1'b0;
                    dir_d   = 1'b1;
                    state_d = S_SERVE;
                    reset_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            score_q <= '0;
            reset_q <= 1'b0;
            run_q   <= 1'b0;
            dir_q   <= 1'b1;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            reset_q <= reset_d;
            run_q   <= run_d;
            dir_q   <= dir_d;
            go_q    <= go_d;
            win_q   <= win_d;
            btn_q   <= serve_btn_i;
        end
    end

    assign score_o       = score_q;
    assign ball_reset_o  = reset_q;
    assign ball_run_o    = run_q;
    assign serve_dir_x_o = dir_q;
    assign game_over_o   = go_q;
    assign winner_o      = win_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Bench for pong_rally_ctrl: directed scenarios plus a randomized full game against a score model.
module tb_pong_rally_ctrl;
    logic       clk_div = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic       serve_btn = 1'b0;
    logic [7:0] score;
    logic       ball_reset, ball_run, serve_dir_x, game_over, winner;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    pong_rally_ctrl dut (
        .clk_div      (clk_div),
        .rst_n        (rst_n),
        .ball_x_i     (ball_x),
        .serve_btn_i  (serve_btn),
        .score_o      (score),
        .ball_reset_o (ball_reset),
        .ball_run_o   (ball_run),
        .serve_dir_x_o(serve_dir_x),
        .game_over_o  (game_over),
        .winner_o     (winner),
        .state_o      (state)
    );

    always #5 clk_div = ~clk_div;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_div);
            #1;
        end
    endtask

    // Reset, one serve press, then wait out the serve delay: lands in RALLY with score 0.
    task automatic go_rally();
        rst_n = 1'b0; ball_x = 10'd320; serve_btn = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        serve_btn = 1'b1;
        step(1);
        serve_btn = 1'b0;
        step(30);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; serve_btn = 1'b0; ball_x = 10'd320;
        step(2);
        total++; if (score !== 8'h00) begin bad++; $display("FAIL reset_score got=%h want=00", score); end
        total++; if (ball_reset !== 1'b0 || ball_run !== 1'b0) begin bad++; $display("FAIL reset_ball got=%b%b want=00", ball_reset, ball_run); end
        total++; if (serve_dir_x !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", serve_dir_x); end
        total++; if (game_over !== 1'b0 || winner !== 1'b0) begin bad++; $display("FAIL reset_go got=%b%b want=00", game_over, winner); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        rst_n = 1'b1;
    endtask

    task automatic test_serve();
        int rst_frames = 0;
        int rise = -1;
        step(5);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_wait got=%0d want=0", state); end
        serve_btn = 1'b1;
        step(1);
        serve_btn = 1'b0;
        total++; if (ball_reset !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL serve_entry got=%b/%0d want=1/1", ball_reset, state); end
        rst_frames = 1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (ball_reset) rst_frames++;
            if (ball_run && rise < 0) rise = k;
        end
        total++; if (rst_frames != 1) begin bad++; $display("FAIL serve_pulse got=%0d want=1", rst_frames); end
        total++; if (rise != 30) begin bad++; $display("FAIL serve_run_rise got=%0d want=30", rise); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL serve_state got=%0d want=2", state); end
    endtask

    task automatic test_left_goal();
        int rs = -1;
        int rr = -1;
        go_rally();
        ball_x = 10'd8;
        step(1);
        ball_x = 10'd320;
        total++; if (score !== 8'h01) begin bad++; $display("FAIL left_score got=%h want=01", score); end
        total++; if (ball_run !== 1'b0 || serve_dir_x !== 1'b0) begin bad++; $display("FAIL left_ctrl got=run%b dir%b want=run0 dir0", ball_run, serve_dir_x); end
        for (int k = 1; k <= 120; k++) begin
            step(1);
            if (ball_reset && rs < 0) rs = k;
            if (ball_run && rr < 0) rr = k;
        end
        total++; if (rs != 60) begin bad++; $display("FAIL left_reset_at got=%0d want=60", rs); end
        total++; if (rr != 90) begin bad++; $display("FAIL left_run_at got=%0d want=90", rr); end
    endtask

    task automatic test_right_goal();
        go_rally();
        ball_x = 10'd632;
        step(1);
        ball_x = 10'd320;
        total++; if (score !== 8'h10) begin bad++; $display("FAIL right_score got=%h want=10", score); end
        total++; if (serve_dir_x !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL right_ctrl got=dir%b st%0d want=dir1 st3", serve_dir_x, state); end
    endtask

    task automatic test_game_over();
        go_rally();
        for (int i = 0; i < 10; i++) begin
            ball_x = 10'd632; step(1);
            ball_x = 10'd320; step(90);
        end
        total++; if (score !== 8'hA0) begin bad++; $display("FAIL go_pre got=%h want=a0", score); end
        ball_x = 10'd632; step(1); ball_x = 10'd320;
        total++; if (score !== 8'hB0) begin bad++; $display("FAIL go_score got=%h want=b0", score); end
        step(60);
        total++; if (game_over !== 1'b1 || winner !== 1'b0 || state !== 3'd4) begin bad++; $display("FAIL go_enter got=go%b w%b st%0d want=go1 w0 st4", game_over, winner, state); end
        step(50);
        total++; if (ball_run !== 1'b0 || score !== 8'hB0) begin bad++; $display("FAIL go_hold got=run%b sc%h want=run0 scb0", ball_run, score); end
        serve_btn = 1'b1; step(1); serve_btn = 1'b0;
        total++; if (score !== 8'h00 || game_over !== 1'b0 || ball_reset !== 1'b1 || serve_dir_x !== 1'b1)
            begin bad++; $display("FAIL go_restart got=sc%h go%b rs%b dir%b want=sc00 go0 rs1 dir1", score, game_over, ball_reset, serve_dir_x); end
    endtask

    task automatic test_held_button();
        int pulses = 0;
        int entries = 0;
        logic [2:0] prev;
        rst_n = 1'b0; serve_btn = 1'b0; ball_x = 10'd320;
        step(2);
        rst_n = 1'b1;
        serve_btn = 1'b1;
        prev = state;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (ball_reset) pulses++;
            if (state == 3'd1 && prev != 3'd1) entries++;
            prev = state;
        end
        serve_btn = 1'b0;
        total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
        total++; if (entries != 1) begin bad++; $display("FAIL held_entries got=%0d want=1", entries); end
    endtask

    task automatic test_reset_mid_rally();
        go_rally();
        for (int i = 0; i < 8; i++) begin
            ball_x = (i < 5) ? 10'd5 : 10'd700; step(1);
            ball_x = 10'd320; step(90);
        end
        total++; if (score !== 8'h35 || state !== 3'd2) begin bad++; $display("FAIL mid_pre got=sc%h st%0d want=sc35 st2", score, state); end
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        total++; if (score !== 8'h00 || state !== 3'd0 || ball_run !== 1'b0) begin bad++; $display("FAIL mid_reset got=sc%h st%0d run%b want=sc00 st0 run0", score, state, ball_run); end
    endtask

    // Random full game: the model is just two point tallies and the side of the last goal.
    task automatic test_random_game();
        int p = 0;
        int o = 0;
        int n;
        logic left;
        logic [7:0] exp;
        go_rally();
        for (int g = 0; g < 30 && p < 11 && o < 11; g++) begin
            n = $urandom_range(0, 12);
            for (int f = 0; f < n; f++) begin
                case ($urandom_range(0, 3))
                    0: ball_x = 10'd11;
                    1: ball_x = 10'd629;
                    default: ball_x = 10'($urandom_range(11, 629));
                endcase
                step(1);
                exp = {4'(o), 4'(p)};
                total++; if (ball_run !== 1'b1 || score !== exp) begin bad++; $display("FAIL rnd_rally got=run%b sc%h want=run1 sc%h", ball_run, score, exp); end
            end
            left = 1'($urandom_range(0, 1));
            if (left) ball_x = $urandom_range(0, 1) ? 10'd10 : 10'($urandom_range(0, 10));
            else      ball_x = $urandom_range(0, 1) ? 10'd630 : 10'($urandom_range(630, 1023));
            if (left) p++; else o++;
            step(1);
            ball_x = 10'd320;
            exp = {4'(o), 4'(p)};
            total++; if (score !== exp || serve_dir_x !== ~left || ball_run !== 1'b0)
                begin bad++; $display("FAIL rnd_goal got=sc%h dir%b run%b want=sc%h dir%b run0", score, serve_dir_x, ball_run, exp, ~left); end
            if (p == 11 || o == 11) begin
                step(60);
                total++; if (game_over !== 1'b1 || winner !== (p == 11)) begin bad++; $display("FAIL rnd_end got=go%b w%b want=go1 w%b", game_over, winner, p == 11); end
            end else begin
                step(90);
                total++; if (ball_run !== 1'b1 || state !== 3'd2) begin bad++; $display("FAIL rnd_resume got=run%b st%0d want=run1 st2", ball_run, state); end
            end
        end
    endtask

    task automatic test_auto_serve();
        int rs = -1;
        int rr = -1;
        rst_n = 1'b0; serve_btn = 1'b0; ball_x = 10'd320;
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step(1);
            if (ball_reset && rs < 0) rs = k;
            if (ball_run && rr < 0) rr = k;
        end
        total++; if (rs != 30) begin bad++; $display("FAIL auto_reset_at got=%0d want=30", rs); end
        total++; if (rr != 60) begin bad++; $display("FAIL auto_run_at got=%0d want=60", rr); end
    endtask

    initial begin
        test_reset();
`ifdef PONG_AUTO_SERVE_EN
        test_auto_serve();
`else
        test_serve();
        test_left_goal();
        test_right_goal();
        test_game_over();
        test_held_button();
        test_reset_mid_rally();
        test_random_game();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
